// File: rtl/mont_const_gen.sv
`default_nettype none
// ============================================================================
//  Module   : mont_const_gen
//  Purpose  : Montgomery constants R mod N and R^2 mod N (R = 2^WIDTH) by
//             serial modular doubling; optional n0' = -N^-1 mod 2^NP_WIDTH
//             when MONT_CONST_NPRIME_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module mont_const_gen #(
   parameter int WIDTH    = 1024,
   parameter int NP_WIDTH = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [WIDTH-1:0]    n_in,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [WIDTH-1:0]    r_mod_n,
   output logic [WIDTH-1:0]    r2_mod_n
`ifdef MONT_CONST_NPRIME_EN
   ,
   output logic [NP_WIDTH-1:0] n0_prime
`endif
);

   localparam int                  c_STEP_W   = $clog2(2*WIDTH+1);
   localparam logic [c_STEP_W-1:0] c_STEP_R   = c_STEP_W'(WIDTH);
   localparam logic [c_STEP_W-1:0] c_STEP_END = c_STEP_W'(2*WIDTH);
   localparam logic [c_STEP_W-1:0] c_STEP_ONE = c_STEP_W'(1);
   localparam logic [WIDTH-1:0]    c_X_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   logic [WIDTH-1:0]    r_nreg;
   logic [WIDTH-1:0]    r_x;
   logic [c_STEP_W-1:0] r_step;

   logic [WIDTH-1:0]    w_s_lo;
   logic                w_ge;
   logic [WIDTH-1:0]    w_diff;
   logic [WIDTH-1:0]    w_x_next;
   logic [c_STEP_W-1:0] w_step_next;
   logic                w_n_bad;
   logic                w_accept;

   // s = 2x is WIDTH+1 bits; its top bit is x's MSB. Because s - N < N the
   // WIDTH-bit truncated difference is exact whenever the subtract is taken.
   assign w_s_lo      = {r_x[WIDTH-2:0], 1'b0};
   assign w_ge        = r_x[WIDTH-1] | (w_s_lo >= r_nreg);
   assign w_diff      = w_s_lo - r_nreg;
   assign w_x_next    = w_ge ? w_diff : w_s_lo;
   assign w_step_next = r_step + c_STEP_ONE;

`ifdef MONT_CONST_NPRIME_EN
   assign w_n_bad = ~(|n_in[WIDTH-1:1]) | ~n_in[0];
`else
   assign w_n_bad = ~(|n_in[WIDTH-1:1]);
`endif

   assign w_accept = (r_state == S_IDLE) && start && !w_n_bad;

`ifdef MONT_CONST_NPRIME_EN
   localparam logic [NP_WIDTH-1:0] c_NP_ONE = {{(NP_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [31:0]         c_NP_W   = NP_WIDTH;

   logic [NP_WIDTH-1:0] r_y;
   logic [NP_WIDTH-1:0] r_t;
   logic [NP_WIDTH-1:0] w_n_lo;
   logic [NP_WIDTH-1:0] w_n_lo_in;
   logic [NP_WIDTH-1:0] w_bit_mask;
   logic                w_inv_act;
   logic                w_inv_fix;
   logic [NP_WIDTH-1:0] w_y_next;
   logic [NP_WIDTH-1:0] w_t_next;

   generate
      if (NP_WIDTH <= WIDTH) begin : g_nlo_trunc
         assign w_n_lo    = r_nreg[NP_WIDTH-1:0];
         assign w_n_lo_in = n_in[NP_WIDTH-1:0];
      end else begin : g_nlo_ext
         assign w_n_lo    = {{(NP_WIDTH-WIDTH){1'b0}}, r_nreg};
         assign w_n_lo_in = {{(NP_WIDTH-WIDTH){1'b0}}, n_in};
      end
   endgenerate

   // Invariant t = N*y mod 2^NP_WIDTH; forcing every bit of t to one drives
   // N*y to -1, so y itself converges to -N^-1 and is output unnegated.
   assign w_bit_mask = c_NP_ONE << r_step;
   assign w_inv_act  = (r_state == S_RUN) && (r_step != '0) && (32'(r_step) < c_NP_W);
   assign w_inv_fix  = w_inv_act && !(|(r_t & w_bit_mask));
   assign w_y_next   = w_inv_fix ? (r_y | w_bit_mask) : r_y;
   assign w_t_next   = w_inv_fix ? (r_t + (w_n_lo << r_step)) : r_t;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y <= '0;
         r_t <= '0;
      end else if (w_accept) begin
         r_y <= c_NP_ONE;
         r_t <= w_n_lo_in;
      end else begin
         r_y <= w_y_next;
         r_t <= w_t_next;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_nreg   <= '0;
         r_x      <= '0;
         r_step   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         r_mod_n  <= '0;
         r2_mod_n <= '0;
`ifdef MONT_CONST_NPRIME_EN
         n0_prime <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_n_bad) begin
                     done     <= 1'b1;
                     err      <= 1'b1;
                     r_mod_n  <= '0;
                     r2_mod_n <= '0;
`ifdef MONT_CONST_NPRIME_EN
                     n0_prime <= '0;
`endif
                  end else begin
                     r_nreg  <= n_in;
                     r_x     <= c_X_ONE;
                     r_step  <= '0;
                     busy    <= 1'b1;
                     err     <= 1'b0;
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_x    <= w_x_next;
               r_step <= w_step_next;
               if (w_step_next == c_STEP_R) begin
                  r_mod_n <= w_x_next;
               end
               if (w_step_next == c_STEP_END) begin
                  r2_mod_n <= w_x_next;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  r_state  <= S_IDLE;
`ifdef MONT_CONST_NPRIME_EN
                  n0_prime <= w_y_next;
`endif
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mont_const_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mont_const_gen
//  Purpose  : Directed and random checks of mont_const_gen (WIDTH=8,
//             NP_WIDTH=8) against arithmetic reference values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mont_const_gen;

   localparam int W   = 8;
   localparam int NPW = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] n_in  = '0;
   logic         busy;
   logic         done;
   logic         err;
   logic [W-1:0] r_mod_n;
   logic [W-1:0] r2_mod_n;
`ifdef MONT_CONST_NPRIME_EN
   logic [NPW-1:0] n0_prime;
`endif

   int checks = 0;
   int errors = 0;
   int lat;
   bit busy_seen;

   always #5 clk = ~clk;

   mont_const_gen #(
      .WIDTH   (W),
      .NP_WIDTH(NPW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .n_in    (n_in),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .r_mod_n (r_mod_n),
`ifdef MONT_CONST_NPRIME_EN
      .n0_prime(n0_prime),
`endif
      .r2_mod_n(r2_mod_n)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit is_bad(input int n);
`ifdef MONT_CONST_NPRIME_EN
      return (n < 2) || (n % 2 == 0);
`else
      return n < 2;
`endif
   endfunction

   function automatic int ref_pow2_mod(input int e, input int n);
      longint p = longint'(1) << e;
      return int'(p % longint'(n));
   endfunction

   // -N^-1 mod 2^NPW: the y with N*y + 1 divisible by 2^NPW
   function automatic int ref_nprime(input int n);
      for (int y = 0; y < (1 << NPW); y++)
         if (((n * y) + 1) % (1 << NPW) == 0) return y;
      return -1;
   endfunction

   // Called at a negedge: presents the request, then waits (bounded) for done.
   task automatic launch(input logic [W-1:0] n);
      start = 1'b1;
      n_in  = n;
      @(negedge clk);
      start     = 1'b0;
      lat       = 0;
      busy_seen = busy;
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
         busy_seen |= busy;
      end
   endtask

   task automatic check_job(input string tag, input logic [W-1:0] n);
      int nn = int'(n);
      chk({tag, ".done"}, done, 1);
      if (is_bad(nn)) begin
         chk({tag, ".lat"}, lat, 0);
         chk({tag, ".err"}, err, 1);
         chk({tag, ".busy"}, busy_seen, 0);
         chk({tag, ".r"}, r_mod_n, 0);
         chk({tag, ".r2"}, r2_mod_n, 0);
`ifdef MONT_CONST_NPRIME_EN
         chk({tag, ".np"}, n0_prime, 0);
`endif
      end else begin
         chk({tag, ".lat"}, lat, 2 * W);
         chk({tag, ".err"}, err, 0);
         chk({tag, ".r"}, r_mod_n, ref_pow2_mod(W, nn));
         chk({tag, ".r2"}, r2_mod_n, ref_pow2_mod(2 * W, nn));
`ifdef MONT_CONST_NPRIME_EN
         chk({tag, ".np"}, n0_prime, ref_nprime(nn));
`endif
      end
   endtask

   initial begin
      int pulses;
      logic [W-1:0] rn;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.err", err, 0);
      chk("rst.r", r_mod_n, 0);
      chk("rst.r2", r2_mod_n, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle.busy", busy, 0);

      // N=13, explicit values
      @(negedge clk);
      launch(8'd13);
      check_job("n13", 8'd13);
      chk("n13.r_lit", r_mod_n, 9);
      chk("n13.r2_lit", r2_mod_n, 3);
`ifdef MONT_CONST_NPRIME_EN
      chk("n13.np_lit", n0_prime, 59);
`endif
      @(negedge clk);
      chk("n13.pulse", done, 0);

      // N=255 then back-to-back start in the done cycle
      launch(8'd255);
      check_job("n255", 8'd255);
      launch(8'd13);
      check_job("b2b13", 8'd13);

      // degenerate / illegal moduli
      @(negedge clk);
      launch(8'd1);
      check_job("n1", 8'd1);
      @(negedge clk);
      launch(8'd0);
      check_job("n0", 8'd0);
      @(negedge clk);
      launch(8'd200);
      check_job("n200", 8'd200);

      // start held and n_in changed during a run
      @(negedge clk);
      start  = 1'b1;
      n_in   = 8'd13;
      pulses = 0;
      @(negedge clk);
      for (int c = 0; c < 40; c++) begin
         if (c == 3) n_in = 8'd7;
         if (c == 14) start = 1'b0;
         if (done) begin
            pulses++;
            chk("hold.lat", c, 2 * W);
            chk("hold.r", r_mod_n, 9);
            chk("hold.r2", r2_mod_n, 3);
`ifdef MONT_CONST_NPRIME_EN
            chk("hold.np", n0_prime, 59);
`endif
         end
         @(negedge clk);
      end
      chk("hold.pulses", pulses, 1);
      chk("hold.busy", busy, 0);

      // asynchronous reset at step 5
      start = 1'b1;
      n_in  = 8'd13;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid.busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.busy", busy, 0);
      chk("arst.done", done, 0);
      chk("arst.err", err, 0);
      chk("arst.r", r_mod_n, 0);
      chk("arst.r2", r2_mod_n, 0);
`ifdef MONT_CONST_NPRIME_EN
      chk("arst.np", n0_prime, 0);
`endif
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("arst.nodone", pulses, 0);
      launch(8'd13);
      check_job("post_rst13", 8'd13);

      // random moduli
      for (int i = 0; i < 20; i++) begin
         rn = 8'($urandom_range(255));
         @(negedge clk);
         launch(rn);
         check_job("rand", rn);
      end
      for (int i = 0; i < 10; i++) begin
         rn = 8'($urandom_range(127) * 2 + 1);
         @(negedge clk);
         launch(rn);
         check_job("rand_odd", rn);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
